// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out valid-ready bundle for the pixel word packer.
// The packer uses the slave view; the producer/consumer side uses master.
interface pixel_word_packer_if #(
  parameter int INW  = 8,
  parameter int OUTW = 64,
  parameter int LW   = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [INW-1:0]  in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [OUTW-1:0] out_data;
  logic            out_last;
  logic [LW:0]     out_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_count
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_count
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs narrow pixels LSB-lane-first into wide words; in_last flushes a
// zero-padded partial word and reports how many lanes it carries.
module pixel_word_packer #(
  parameter int INLOGBITS  = 3,
  parameter int OUTLOGBITS = 6
) (
  input logic                clk,
  input logic                rst_n,
  pixel_word_packer_if.slave bus
);
  localparam int OUTW = 1 << OUTLOGBITS;
  localparam int LW   = OUTLOGBITS - INLOGBITS;

  localparam logic [INLOGBITS-1:0] LANE_LSB = '0;
  localparam logic [LW:0]          ONE      = {{LW{1'b0}}, 1'b1};

  logic [LW-1:0]   idx_q, idx_d;
  logic [OUTW-1:0] acc_q, acc_d;
  logic            out_valid_q, out_valid_d;
  logic [OUTW-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [LW:0]     out_count_q, out_count_d;

  logic            in_ready;
  logic            accept;
  logic            complete;
  logic [OUTW-1:0] merged;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && ((&idx_q) || bus.in_last);

  // Lanes above idx are still zero, so OR-ing in the new lane is enough.
  assign merged = acc_q
                | (OUTW'(bus.in_data) << {idx_q, LANE_LSB});

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_count_d = out_count_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = merged;
      out_last_d  = bus.in_last;
      out_count_d = {1'b0, idx_q} + ONE;
      idx_d       = '0;
      acc_d       = '0;
    end else if (accept) begin
      idx_d = idx_q + 1'b1;
      acc_d = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_count = out_count_q;
endmodule
